// File: rtl/sbilinear_fetch_pkg.sv
// sbilinear_fetch_pkg: shared FSM state type and shift constants for the bilinear fetch/interpolate path
//   DATA_W_DEF / SHW_DEF : default sample and shift-amount widths
//   sh_zero()            : "zero weight" shift code for a given shift width (all ones)
//   SH_ZERO              : zero-weight code at the default shift width
package sbilinear_fetch_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int SHW_DEF    = 6;
   function automatic int sh_zero(input int shw);
      return (1 << shw) - 1;
   endfunction
   localparam int SH_ZERO = sh_zero(SHW_DEF);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, EMIT} state_t;
endpackage

// File: rtl/sbilinear_addr_gen.sv
// sbilinear_addr_gen: combinational neighbour address and shift-amount generator
//   xc, yc  : clamped top-left coordinate
//   fx, fy  : half-pixel flags
//   idx     : neighbour index (0=(x,y) 1=(x+1,y) 2=(x,y+1) 3=(x+1,y+1))
//   addr    : sample-memory address of neighbour idx
//   s0..s3  : shift amounts for the four neighbours
module sbilinear_addr_gen
   import sbilinear_fetch_pkg::*;
#(
   parameter int SHW    = SHW_DEF,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int X_W    = 10,
   parameter int Y_W    = 10,
   parameter int ADDR_W = 19
) (
   input  logic [X_W-1:0]    xc,
   input  logic [Y_W-1:0]    yc,
   input  logic              fx,
   input  logic              fy,
   input  logic [1:0]        idx,
   output logic [ADDR_W-1:0] addr,
   output logic [SHW-1:0]    s0,
   output logic [SHW-1:0]    s1,
   output logic [SHW-1:0]    s2,
   output logic [SHW-1:0]    s3
);
   localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);
   localparam logic [SHW-1:0] SHZ   = SHW'(sh_zero(SHW));

   logic [X_W-1:0] xs;
   logic [Y_W-1:0] ys;
   logic [SHW-1:0] sum;

   // With no zero-weight axis every neighbour's shift is fx+fy; a far
   // neighbour on an axis with f=0 carries zero weight.
   always_comb begin
      xs   = (idx[0] && xc != X_MAX) ? xc + X_W'(1) : xc;
      ys   = (idx[1] && yc != Y_MAX) ? yc + Y_W'(1) : yc;
      addr = ADDR_W'(ys) * ADDR_W'(IMG_W) + ADDR_W'(xs);
      sum  = SHW'(fx) + SHW'(fy);
      s0   = sum;
      s1   = fx ? sum : SHZ;
      s2   = fy ? sum : SHZ;
      s3   = (fx && fy) ? sum : SHZ;
   end
endmodule

// File: rtl/sbilinear_fetch.sv
// sbilinear_fetch: fetches the four bilinear neighbours of a clamped coordinate and emits them with shift amounts
//   req_valid/req_ready, req_x/req_y, req_fx/req_fy : coordinate request handshake (accepted in IDLE only)
//   mem_req/mem_addr/mem_rdata                      : sample-memory read port, 1-cycle read latency
//   v00..v11, s0..s3, valid_out                     : neighbour bundle, valid for one cycle 6 cycles after acceptance
module sbilinear_fetch
   import sbilinear_fetch_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SHW    = SHW_DEF,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int X_W    = 10,
   parameter int Y_W    = 10,
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [X_W-1:0]    req_x,
   input  logic [Y_W-1:0]    req_y,
   input  logic              req_fx,
   input  logic              req_fy,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] v00,
   output logic [DATA_W-1:0] v01,
   output logic [DATA_W-1:0] v10,
   output logic [DATA_W-1:0] v11,
   output logic [SHW-1:0]    s0,
   output logic [SHW-1:0]    s1,
   output logic [SHW-1:0]    s2,
   output logic [SHW-1:0]    s3,
   output logic              valid_out
);
   localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [X_W-1:0]    xc_q, xc_d;
   logic [Y_W-1:0]    yc_q, yc_d;
   logic              fx_q, fx_d, fy_q, fy_d;
   logic [ADDR_W-1:0] addr_q, addr_d, gen_addr;
   logic [DATA_W-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
   logic [DATA_W-1:0] v00_q, v00_d, v01_q, v01_d, v10_q, v10_d, v11_q, v11_d;
   logic [SHW-1:0]    s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [SHW-1:0]    g0, g1, g2, g3;
   logic              accept, fetch, drain;

   sbilinear_addr_gen #(
      .SHW(SHW), .IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
   ) u_addr_gen (
      .xc(xc_q), .yc(yc_q), .fx(fx_q), .fy(fy_q), .idx(cnt_q),
      .addr(gen_addr), .s0(g0), .s1(g1), .s2(g2), .s3(g3)
   );

   // Reads 0..2 land in a staging buffer while fetching; the whole bundle
   // (with read 3 straight off the bus) moves to the outputs on the
   // DRAIN->EMIT edge so the outputs only change when valid_out rises.
   always_comb begin
      accept  = (state_q == IDLE) && req_valid;
      fetch   = state_q == FETCH;
      drain   = state_q == DRAIN;
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = req_valid ? FETCH : IDLE;
         FETCH:   state_d = (cnt_q == 2'd3) ? DRAIN : FETCH;
         DRAIN:   state_d = EMIT;
         default: state_d = IDLE;
      endcase
      cnt_d  = accept ? 2'd0 : fetch ? cnt_q + 2'd1 : cnt_q;
      xc_d   = accept ? ((req_x > X_MAX) ? X_MAX : req_x) : xc_q;
      yc_d   = accept ? ((req_y > Y_MAX) ? Y_MAX : req_y) : yc_q;
      fx_d   = accept ? req_fx : fx_q;
      fy_d   = accept ? req_fy : fy_q;
      addr_d = fetch ? gen_addr : addr_q;
      b0_d   = (fetch && cnt_q == 2'd1) ? mem_rdata : b0_q;
      b1_d   = (fetch && cnt_q == 2'd2) ? mem_rdata : b1_q;
      b2_d   = (fetch && cnt_q == 2'd3) ? mem_rdata : b2_q;
      v00_d  = drain ? b0_q : v00_q;
      v01_d  = drain ? b1_q : v01_q;
      v10_d  = drain ? b2_q : v10_q;
      v11_d  = drain ? mem_rdata : v11_q;
      s0_d   = drain ? g0 : s0_q;
      s1_d   = drain ? g1 : s1_q;
      s2_d   = drain ? g2 : s2_q;
      s3_d   = drain ? g3 : s3_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         xc_q    <= '0;
         yc_q    <= '0;
         fx_q    <= 1'b0;
         fy_q    <= 1'b0;
         addr_q  <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         b2_q    <= '0;
         v00_q   <= '0;
         v01_q   <= '0;
         v10_q   <= '0;
         v11_q   <= '0;
         s0_q    <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         xc_q    <= xc_d;
         yc_q    <= yc_d;
         fx_q    <= fx_d;
         fy_q    <= fy_d;
         addr_q  <= addr_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         b2_q    <= b2_d;
         v00_q   <= v00_d;
         v01_q   <= v01_d;
         v10_q   <= v10_d;
         v11_q   <= v11_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
      end
   end

   assign req_ready = state_q == IDLE;
   assign valid_out = state_q == EMIT;
   assign mem_req   = fetch;
   assign mem_addr  = fetch ? gen_addr : addr_q;
   assign v00       = v00_q;
   assign v01       = v01_q;
   assign v10       = v10_q;
   assign v11       = v11_q;
   assign s0        = s0_q;
   assign s1        = s1_q;
   assign s2        = s2_q;
   assign s3        = s3_q;
endmodule

// File: tb/tb_sbilinear_fetch.sv
// tb_sbilinear_fetch: scoreboard bench for sbilinear_fetch with directed and random requests
module tb_sbilinear_fetch;
   localparam int DATA_W = 16;
   localparam int SHW    = 6;
   localparam int IMG_W  = 640;
   localparam int IMG_H  = 480;
   localparam int X_W    = 10;
   localparam int Y_W    = 10;
   localparam int ADDR_W = 19;
   localparam int SZ     = (1 << SHW) - 1;

   typedef struct packed {
      logic [3:0][ADDR_W-1:0] a;
      logic [3:0][DATA_W-1:0] v;
      logic [3:0][SHW-1:0]    s;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready, req_fx, req_fy;
   logic [X_W-1:0]    req_x;
   logic [Y_W-1:0]    req_y;
   logic              mem_req, valid_out;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [DATA_W-1:0] v00, v01, v10, v11;
   logic [SHW-1:0]    s0, s1, s2, s3;

   int vec = 0, fails = 0, cyc = 0, n_acc = 0, a_cyc = 0, salt = 0;
   bit active = 0, started = 0, use_dir = 0;
   exp_t dir_exp;
   exp_t exp_q[$];
   logic [ADDR_W-1:0] addr_q[$];
   int acc_log[$];
   logic [DATA_W-1:0] ovr[int];

   sbilinear_fetch #(
      .DATA_W(DATA_W), .SHW(SHW), .IMG_W(IMG_W), .IMG_H(IMG_H),
      .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_fx(req_fx), .req_fy(req_fy),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .v00(v00), .v01(v01), .v10(v10), .v11(v11),
      .s0(s0), .s1(s1), .s2(s2), .s3(s3), .valid_out(valid_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [DATA_W-1:0] memval(input int ad);
      if (ovr.exists(ad)) return ovr[ad];
      return DATA_W'((ad * 40503) ^ salt);
   endfunction

   // Sample memory: data for a strobed read appears one cycle later, junk otherwise.
   always @(posedge clk) mem_rdata <= mem_req ? memval(int'(mem_addr)) : DATA_W'($urandom);

   // Reference: neighbours of the clamped point; per-axis weight 0/1 or -1 for a zero-weight neighbour.
   function automatic exp_t model(input int x, input int y, input bit fx, input bit fy);
      exp_t e;
      int xs[2], ys[2], wx[2], wy[2], ad;
      xs[0] = (x < IMG_W) ? x : IMG_W - 1;
      ys[0] = (y < IMG_H) ? y : IMG_H - 1;
      xs[1] = (xs[0] + 1 < IMG_W) ? xs[0] + 1 : IMG_W - 1;
      ys[1] = (ys[0] + 1 < IMG_H) ? ys[0] + 1 : IMG_H - 1;
      wx[0] = fx ? 1 : 0;
      wx[1] = fx ? 1 : -1;
      wy[0] = fy ? 1 : 0;
      wy[1] = fy ? 1 : -1;
      for (int k = 0; k < 4; k++) begin
         ad = ys[k / 2] * IMG_W + xs[k % 2];
         e.a[k] = ADDR_W'(ad);
         e.v[k] = memval(ad);
         e.s[k] = (wx[k % 2] < 0 || wy[k / 2] < 0) ? SHW'(SZ) : SHW'(wx[k % 2] + wy[k / 2]);
      end
      return e;
   endfunction

   function automatic exp_t mk(input int a0, a1, a2, a3, input int t0, t1, t2, t3);
      exp_t e;
      e.a = {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
      e.v = {memval(a3), memval(a2), memval(a1), memval(a0)};
      e.s = {SHW'(t3), SHW'(t2), SHW'(t1), SHW'(t0)};
      return e;
   endfunction

   // Handshake timing model and stimulus-side scoreboard push.
   always @(negedge clk) begin
      int rel;
      bit er, em, ev;
      exp_t e;
      if (rst_n && started) begin
         rel = active ? cyc - a_cyc + 1 : 0;
         if (active && rel >= 7) active = 0;
         er = !active;
         em = active && rel >= 1 && rel <= 4;
         ev = active && rel == 6;
         vec++;
         if ({req_ready, mem_req, valid_out} !== {er, em, ev}) begin
            fails++;
            $display("FAIL handshake cyc=%0d ready/mem_req/valid_out got %b%b%b want %b%b%b",
                     cyc, req_ready, mem_req, valid_out, er, em, ev);
         end
         if (req_valid && er) begin
            e = use_dir ? dir_exp : model(int'(req_x), int'(req_y), req_fx, req_fy);
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) addr_q.push_back(e.a[k]);
            active = 1;
            a_cyc = cyc + 1;
            acc_log.push_back(cyc);
            n_acc++;
         end
      end
   end

   always @(negedge clk) begin
      logic [ADDR_W-1:0] ea;
      if (rst_n && mem_req) begin
         vec++;
         if (addr_q.size() == 0) begin
            fails++;
            $display("FAIL addr cyc=%0d unexpected read got %0d want none", cyc, mem_addr);
         end else begin
            ea = addr_q.pop_front();
            if (mem_addr !== ea) begin
               fails++;
               $display("FAIL addr cyc=%0d got %0d want %0d", cyc, mem_addr, ea);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && valid_out) begin
         vec++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL bundle cyc=%0d unexpected valid_out got v=%h want none", cyc, {v11, v10, v01, v00});
         end else begin
            e = exp_q.pop_front();
            if ({v11, v10, v01, v00, s3, s2, s1, s0} !== {e.v, e.s}) begin
               fails++;
               $display("FAIL bundle cyc=%0d got v=%h s=%h want v=%h s=%h",
                        cyc, {v11, v10, v01, v00}, {s3, s2, s1, s0}, e.v, e.s);
            end
         end
      end
   end

   task automatic send(input int x, input int y, input bit fx, input bit fy);
      int k;
      k = n_acc;
      req_x = X_W'(x);
      req_y = Y_W'(y);
      req_fx = fx;
      req_fy = fy;
      req_valid = 1'b1;
      for (int i = 0; i < 30 && n_acc == k; i++) begin
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      vec++;
      if (n_acc == k) begin
         fails++;
         $display("FAIL accept (%0d,%0d) got no acceptance want acceptance within 30 cycles", x, y);
      end
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 20; i++) begin
         if (!active && exp_q.size() == 0 && addr_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      vec++;
      if (i == 20) begin
         fails++;
         $display("FAIL drain got %0d bundles pending want 0", exp_q.size());
      end
   endtask

   task automatic issue(input int x, input int y, input bit fx, input bit fy);
      send(x, y, fx, fy);
      wait_done();
   endtask

   initial begin
      salt = int'($urandom);
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_x = '0;
      req_y = '0;
      req_fx = 1'b0;
      req_fy = 1'b0;
      #3;
      vec++;
      if ({req_ready, mem_req, mem_addr, valid_out, v00, v01, v10, v11, s0, s1, s2, s3} !== {1'b1, 1'b0, {ADDR_W{1'b0}}, 1'b0, {(4*DATA_W + 4*SHW){1'b0}}}) begin
         fails++;
         $display("FAIL reset got ready=%b mem_req=%b addr=%0d valid=%b v=%h s=%h want 1 0 0 0 0 0",
                  req_ready, mem_req, mem_addr, valid_out, {v11, v10, v01, v00}, {s3, s2, s1, s0});
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      started = 1;

      use_dir = 1;
      dir_exp = mk(12810, 12811, 13450, 13451, 0, SZ, SZ, SZ);
      issue(10, 20, 0, 0);
      ovr[3205] = 16'd100;
      ovr[3206] = 16'd200;
      ovr[3845] = 16'd300;
      ovr[3846] = 16'd400;
      dir_exp = mk(3205, 3206, 3845, 3846, 2, 2, 2, 2);
      vec++;
      if (dir_exp.v !== {16'd400, 16'd300, 16'd200, 16'd100}) begin
         fails++;
         $display("FAIL memsetup got %h want 0190012c00c80064", dir_exp.v);
      end
      issue(5, 5, 1, 1);
      dir_exp = mk(307199, 307199, 307199, 307199, 1, 1, SZ, SZ);
      issue(639, 479, 1, 0);
      dir_exp = mk(307199, 307199, 307199, 307199, 1, SZ, 1, SZ);
      issue(1000, 900, 0, 1);
      use_dir = 0;

      acc_log.delete();
      req_x = X_W'(37);
      req_y = Y_W'(479);
      req_fx = 1'b1;
      req_fy = 1'b1;
      req_valid = 1'b1;
      for (int i = 0; i < 40 && acc_log.size() < 3; i++) begin
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      wait_done();
      vec++;
      if (acc_log.size() != 3 || acc_log[1] - acc_log[0] != 7 || acc_log[2] - acc_log[1] != 7) begin
         fails++;
         $display("FAIL b2b got %0d acceptances spacing %0d want 3 spacing 7",
                  acc_log.size(), acc_log.size() > 1 ? acc_log[1] - acc_log[0] : 0);
      end

      send(200, 100, 1, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      vec++;
      if ({mem_req, valid_out, req_ready, mem_addr} !== {1'b0, 1'b0, 1'b1, {ADDR_W{1'b0}}}) begin
         fails++;
         $display("FAIL midreset got mem_req=%b valid=%b ready=%b addr=%0d want 0 0 1 0",
                  mem_req, valid_out, req_ready, mem_addr);
      end
      exp_q.delete();
      addr_q.delete();
      active = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(100, 50, 1, 1);

      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #1;
         req_valid = ($urandom_range(0, 2) != 0);
         req_x = X_W'($urandom_range(0, 1023));
         req_y = Y_W'($urandom_range(0, 1023));
         req_fx = 1'($urandom);
         req_fy = 1'($urandom);
      end
      req_valid = 1'b0;
      wait_done();
      repeat (3) @(posedge clk);
      #1;
      vec++;
      if (exp_q.size() != 0 || addr_q.size() != 0) begin
         fails++;
         $display("FAIL leftover got %0d bundles %0d addrs want 0 0", exp_q.size(), addr_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
      $finish;
   end
endmodule
